// File: rtl/simplebus_arbiter_if.sv
// Purpose : bundles the requester-side handshake and the SimpleBus command/response
//           signals of simplebus_arbiter into one interface.
// Ports   : req_valid/req_op/req_addr/req_wr_data in, req_ack/req_rd_data out;
//           bus_cmd_valid/bus_op/bus_addr/bus_wr_data out, bus_rd_data in; busy out.
//           modport master = arbiter view (it masters the SimpleBus),
//           modport slave  = environment view (requesters plus bus target).
interface simplebus_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_op;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wr_data;
   logic [NUM_REQ-1:0]        req_ack;
   logic [DATA_W-1:0]         req_rd_data;
   logic                      bus_cmd_valid;
   logic                      bus_op;
   logic [ADDR_W-1:0]         bus_addr;
   logic [DATA_W-1:0]         bus_wr_data;
   logic [DATA_W-1:0]         bus_rd_data;
   logic                      busy;

   modport master (
      input  req_valid, req_op, req_addr, req_wr_data, bus_rd_data,
      output req_ack, req_rd_data, bus_cmd_valid, bus_op, bus_addr, bus_wr_data, busy
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wr_data, bus_rd_data,
      input  req_ack, req_rd_data, bus_cmd_valid, bus_op, bus_addr, bus_wr_data, busy
   );
endinterface

// File: rtl/simplebus_arbiter.sv
// Purpose : shares one SimpleBus register-access port between NUM_REQ requesters,
//           one transaction at a time, round-robin; returns read data to the winner.
// Ports   : clk, rst (async, active-high), sb (simplebus_arbiter_if.master).
//           Write ack one cycle after the command cycle, read ack RD_LAT+1 after it;
//           losers simply stay pending until granted.
module simplebus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int RD_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   simplebus_arbiter_if.master  sb
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
   localparam logic [PTR_W:0]   NREQ     = (PTR_W + 1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   win;
   logic [CNT_W-1:0]   rd_cnt;
   logic [NUM_REQ-1:0] win_onehot;

   logic               found;
   logic [PTR_W-1:0]   pick;
   logic [PTR_W:0]     cand;

   // First pending requester at or above rr_ptr, wrapping past the top index.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!found && sb.req_valid[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[PTR_W-1:0];
         end
      end
   end

   assign win_onehot = NUM_REQ'(1) << win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         win              <= '0;
         rd_cnt           <= '0;
         sb.req_ack       <= '0;
         sb.req_rd_data   <= '0;
         sb.bus_cmd_valid <= 1'b0;
         sb.bus_op        <= 1'b0;
         sb.bus_addr      <= '0;
         sb.bus_wr_data   <= '0;
         sb.busy          <= 1'b0;
      end else begin
         // Strobes are single-cycle; every state re-asserts them only when needed.
         sb.req_ack       <= '0;
         sb.bus_cmd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  win              <= pick;
                  sb.bus_op        <= sb.req_op[pick];
                  sb.bus_addr      <= sb.req_addr[int'(pick) * ADDR_W +: ADDR_W];
                  sb.bus_wr_data   <= sb.req_wr_data[int'(pick) * DATA_W +: DATA_W];
                  sb.bus_cmd_valid <= 1'b1;
                  sb.busy          <= 1'b1;
                  state            <= CMD;
               end
            end
            CMD: begin
               // bus_op still holds the latched op of this transaction.
               if (sb.bus_op) begin
                  sb.req_ack <= win_onehot;
                  state      <= DONE;
               end else begin
                  rd_cnt <= CNT_W'(RD_LAT - 1);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               // rd_cnt reaches zero in the cycle the target presents read data.
               if (rd_cnt == '0) begin
                  sb.req_rd_data <= sb.bus_rd_data;
                  sb.req_ack     <= win_onehot;
                  state          <= DONE;
               end else begin
                  rd_cnt <= rd_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               rr_ptr  <= (win == LAST_REQ) ? '0 : win + PTR_W'(1);
               sb.busy <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
